// File: rtl/kbd_tx_protocol.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits, odd parity, stop, ACK.
// Define KBD_TX_RETRY_EN to retry a NACKed or timed-out frame once before tx_err.
module kbd_tx_protocol #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_XFER,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic [7:0]    clk_samples;
    logic [1:0]    data_sync;
    logic [7:0]    data_q;
    logic          parity_q;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] wd_cnt;
    logic          ack_ok;
    logic          fall;
    logic          lines_idle;
    logic          watched;
    logic          wd_expired;
    logic          nack_done;
    logic          fail_now;
    logic          retry_ok;

`ifdef KBD_TX_RETRY_EN
    logic retried;
    assign retry_ok = ~retried;
`else
    assign retry_ok = 1'b0;
`endif

    // Four stable samples on each side of the edge filter out line glitches
    assign fall       = (clk_samples[7:4] == 4'hF) && (clk_samples[3:0] == 4'h0);
    assign lines_idle = (clk_samples[3:0] == 4'hF) && data_sync[1];

    assign watched    = (state == S_XFER) || (state == S_ACK) ||
                        (state == S_WAIT_IDLE);
    assign wd_expired = watched && !fall && (wd_cnt == WD_LAST);
    assign nack_done  = (state == S_WAIT_IDLE) && lines_idle && !ack_ok;
    assign fail_now   = nack_done ||
                        (wd_expired && !((state == S_WAIT_IDLE) && lines_idle));

    assign tx_ready = (state == S_IDLE);
    assign tx_busy  = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            clk_samples <= 8'hFF;
            data_sync   <= 2'b11;
            data_q      <= '0;
            parity_q    <= 1'b0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            wd_cnt      <= '0;
            ack_ok      <= 1'b0;
            ps2clk_oe   <= 1'b0;
            ps2data_oe  <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
`ifdef KBD_TX_RETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            clk_samples <= {clk_samples[6:0], ps2clk};
            data_sync   <= {data_sync[0], ps2data};
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;

            if (watched) begin
                wd_cnt <= fall ? '0 : wd_cnt + TW'(1);
            end

            if (fail_now) begin
                ps2clk_oe  <= retry_ok;
                ps2data_oe <= 1'b0;
                inh_cnt    <= '0;
                bit_cnt    <= '0;
                wd_cnt     <= '0;
                tx_err     <= ~retry_ok;
                state      <= retry_ok ? S_INHIBIT : S_IDLE;
`ifdef KBD_TX_RETRY_EN
                retried    <= 1'b1;
`endif
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (tx_valid) begin
                            data_q    <= tx_data;
                            parity_q  <= ~^tx_data;
                            inh_cnt   <= '0;
                            ps2clk_oe <= 1'b1;
                            state     <= S_INHIBIT;
`ifdef KBD_TX_RETRY_EN
                            retried   <= 1'b0;
`endif
                        end
                    end
                    S_INHIBIT: begin
                        inh_cnt <= inh_cnt + IW'(1);
                        if (inh_cnt == INH_START) begin
                            ps2data_oe <= 1'b1;
                        end
                        if (inh_cnt == INH_LAST) begin
                            ps2clk_oe <= 1'b0;
                            inh_cnt   <= '0;
                            bit_cnt   <= '0;
                            wd_cnt    <= '0;
                            state     <= S_XFER;
                        end
                    end
                    S_XFER: begin
                        if (fall) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt < 4'd8) begin
                                ps2data_oe <= ~data_q[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2data_oe <= ~parity_q;
                            end else begin
                                ps2data_oe <= 1'b0;
                                bit_cnt    <= '0;
                                state      <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (fall) begin
                            ack_ok <= ~data_sync[1];
                            state  <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        // NACK completion is taken by fail_now above
                        if (lines_idle) begin
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kbd_tx_protocol.sv
// Scoreboard bench for kbd_tx_protocol with a PS/2 device model.
// Build with +define+KBD_TX_RETRY_EN to check the retry variant.
module tb_kbd_tx_protocol;

    localparam int INH  = 50;
    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_init = 1'b1;
    logic       dev_rst = 1'b0;
    logic       reset;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2clk;
    logic       ps2data;
    logic       ps2clk_oe;
    logic       ps2data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign reset   = rst_init | dev_rst;
    assign ps2clk  = ~(ps2clk_oe | dev_clk_low);
    assign ps2data = ~(ps2data_oe | dev_data_low);

    kbd_tx_protocol #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .ps2clk_oe (ps2clk_oe),
        .ps2data_oe(ps2data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         ack;
        int         stop_at;
        int         rst_at;
        bit         last;
    } frame_t;

    frame_t exp_frames[$];
    bit     exp_res[$];
    bit     dev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: every done/err pulse is matched against the queue
    always @(negedge clk) begin
        if (!reset && (tx_done || tx_err)) begin
            if (exp_res.size() == 0) begin
                check("unexpected_result", 32'({tx_done, tx_err}), 32'd0);
            end else begin
                bit e;
                e = exp_res.pop_front();
                check("result", 32'({tx_done, tx_err}),
                      e ? 32'd2 : 32'd1);
            end
        end
    end

    // Device model: clocks the frame, samples on rise, ACKs on clock 11
    initial begin : device
        frame_t      f;
        int          n;
        int          t_fall;
        logic [9:0]  bits;
        bit          aborted;
        wait (rst_init == 1'b0);
        forever begin
            while (ps2clk_oe !== 1'b1) @(negedge clk);
            dev_busy = 1'b1;
            n = 0;
            while (ps2clk_oe === 1'b1 && n < 10000) begin
                n++;
                @(negedge clk);
            end
            if (exp_frames.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
                f.data = 8'h00; f.par = 1'b1; f.ack = 1'b1;
                f.stop_at = 10; f.rst_at = 0; f.last = 1'b1;
            end else begin
                f = exp_frames.pop_front();
            end
            check("inhibit_len", n, INH);
            check("start_bit", 32'(ps2data), 32'd0);
            bits = '1;
            aborted = 1'b0;
            t_fall = cyc;
            repeat (HALF) @(negedge clk);
            for (int k = 1; k <= 10; k++) begin
                if (k > f.stop_at) break;
                dev_clk_low = 1'b1;
                t_fall = cyc;
                if (k == f.rst_at) begin
                    repeat (8) @(negedge clk);
                    dev_rst = 1'b1;
                    #1;
                    check("rst_oe", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
                    check("rst_ready", 32'(tx_ready), 32'd1);
                    repeat (3) @(negedge clk);
                    dev_rst = 1'b0;
                    dev_clk_low = 1'b0;
                    @(negedge clk);
                    check("ready_after_rst", 32'(tx_ready), 32'd1);
                    aborted = 1'b1;
                    break;
                end
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                bits[k-1] = ps2data;
                repeat (HALF) @(negedge clk);
            end
            if (aborted) begin
            end else if (f.stop_at < 10) begin
                n = 0;
                while (!tx_err && !ps2clk_oe && n < TO + 100) begin
                    n++;
                    @(negedge clk);
                end
                // 4-sample filter plus one register stage precede the watchdog
                check("timeout_latency", cyc - t_fall, TO + 5);
                if (f.last) begin
                    check("timeout_oe", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
                end else begin
                    check("retry_inhibit", 32'(ps2clk_oe), 32'd1);
                end
            end else begin
                dev_data_low = f.ack;
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF / 2) @(negedge clk);
                dev_data_low = 1'b0;
                check("data_bits", 32'(bits[7:0]), 32'(f.data));
                check("parity_bit", 32'(bits[8]), 32'(f.par));
                check("stop_bit", 32'(bits[9]), 32'd1);
            end
            dev_busy = 1'b0;
        end
    end

    task automatic expect_frame(input logic [7:0] d, input logic p,
                                input bit ack, input int stop_at,
                                input int rst_at);
        frame_t f;
        f.data = d; f.par = p; f.ack = ack;
        f.stop_at = stop_at; f.rst_at = rst_at; f.last = 1'b1;
`ifdef KBD_TX_RETRY_EN
        if ((!ack || stop_at < 10) && rst_at == 0) begin
            f.last = 1'b0;
            exp_frames.push_back(f);
            f.last = 1'b1;
        end
`endif
        exp_frames.push_back(f);
        if (rst_at == 0) exp_res.push_back(ack && stop_at >= 10);
    endtask

    task automatic issue(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while (!(exp_frames.size() == 0 && exp_res.size() == 0 &&
                 !dev_busy && tx_ready === 1'b1) && n < 20000) begin
            n++;
            @(negedge clk);
        end
        check({name, "_complete"}, 32'(n < 20000), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2data_oe), 32'd0);
        rst_init = 1'b0;
        repeat (20) @(negedge clk);

        expect_frame(8'hED, 1'b1, 1'b1, 10, 0);
        issue(8'hED);
        wait_quiet("send_ed");

        expect_frame(8'h00, 1'b1, 1'b1, 10, 0);
        issue(8'h00);
        wait_quiet("send_00");

        expect_frame(8'h01, 1'b0, 1'b1, 10, 0);
        issue(8'h01);
        wait_quiet("send_01");

        expect_frame(8'hA5, 1'b1, 1'b0, 10, 0);
        issue(8'hA5);
        wait_quiet("nack_a5");

        expect_frame(8'h5A, 1'b1, 1'b1, 4, 0);
        issue(8'h5A);
        wait_quiet("timeout_5a");

        expect_frame(8'h00, 1'b1, 1'b1, 10, 5);
        issue(8'h00);
        wait_quiet("reset_mid");

        expect_frame(8'hFF, 1'b1, 1'b1, 10, 0);
        issue(8'hFF);
        wait_quiet("send_ff");

        expect_frame(8'h3C, 1'b1, 1'b1, 10, 0);
        issue(8'h3C);
        repeat (150) @(negedge clk);
        check("busy_ready", 32'(tx_ready), 32'd0);
        check("busy_busy", 32'(tx_busy), 32'd1);
        tx_data = 8'hF0;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_quiet("ignore_f0");
        repeat (100) @(negedge clk);
        check("no_second_frame", 32'(ps2clk_oe), 32'd0);
        check("idle_after", 32'(tx_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
